// File: rtl/karatsuba_ctrl16.sv
// karatsuba_ctrl16: sequential 16x16 unsigned multiplier built around one
// combinational 8x8 Karatsuba core. Three partial products (low, high, cross)
// are formed on consecutive cycles and recombined in a final cycle.

// KaratsubaCore8: combinational 8x8 unsigned multiply, itself split into
// 4-bit halves so the cross term needs only one extra narrow multiply.
module KaratsubaCore8 (
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
    output logic [15:0] Z
);

    logic [3:0] x_hi;
    logic [3:0] x_lo;
    logic [3:0] y_hi;
    logic [3:0] y_lo;
    logic [7:0] prod_lo;
    logic [7:0] prod_hi;
    logic [4:0] sum_x;
    logic [4:0] sum_y;
    logic [9:0] prod_cross;
    logic [9:0] mid_term;

    // Karatsuba on nibbles: mid_term = xh*yl + xl*yh, at most 450, fits 10 bits
    always_comb begin
        x_hi       = X[7:4];
        x_lo       = X[3:0];
        y_hi       = Y[7:4];
        y_lo       = Y[3:0];
        prod_lo    = {4'b0, x_lo} * {4'b0, y_lo};
        prod_hi    = {4'b0, x_hi} * {4'b0, y_hi};
        sum_x      = {1'b0, x_hi} + {1'b0, x_lo};
        sum_y      = {1'b0, y_hi} + {1'b0, y_lo};
        prod_cross = {5'b0, sum_x} * {5'b0, sum_y};
        mid_term   = prod_cross - {2'b0, prod_hi} - {2'b0, prod_lo};
        Z          = {prod_hi, 8'b0} + {2'b0, mid_term, 4'b0} + {8'b0, prod_lo};
    end

endmodule

module karatsuba_ctrl16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M2,
        M1,
        COMB,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] z0;
    logic [15:0] z2;
    logic [17:0] mid;

    logic [8:0]  sa;
    logic [8:0]  sb;
    logic [7:0]  core_x;
    logic [7:0]  core_y;
    logic [15:0] core_z;
    logic [17:0] mid_next;
    logic [17:0] z1;
    logic [31:0] p_next;

    // The single shared 8x8 multiplier; its operands are steered by state
    KaratsubaCore8 core (
        .X (core_x),
        .Y (core_y),
        .Z (core_z)
    );

    // Operand steering plus the 9-bit sum correction and final recombination
    always_comb begin
        sa = {1'b0, a_reg[15:8]} + {1'b0, a_reg[7:0]};
        sb = {1'b0, b_reg[15:8]} + {1'b0, b_reg[7:0]};
        case (state)
            M0: begin
                core_x = a_reg[7:0];
                core_y = b_reg[7:0];
            end
            M2: begin
                core_x = a_reg[15:8];
                core_y = b_reg[15:8];
            end
            default: begin
                core_x = sa[7:0];
                core_y = sb[7:0];
            end
        endcase
        mid_next = {2'b0, core_z}
                 + (sa[8] ? {2'b0, sb[7:0], 8'b0} : 18'd0)
                 + (sb[8] ? {2'b0, sa[7:0], 8'b0} : 18'd0)
                 + ((sa[8] & sb[8]) ? 18'h10000 : 18'd0);
        z1       = mid - {2'b0, z2} - {2'b0, z0};
        p_next   = {z2, 16'b0} + {6'b0, z1, 8'b0} + {16'b0, z0};
    end

    // Control FSM; handshake outputs are registered alongside the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= 32'd0;
            a_reg     <= 16'd0;
            b_reg     <= 16'd0;
            z0        <= 16'd0;
            z2        <= 16'd0;
            mid       <= 18'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        state    <= M0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                M0: begin
                    z0    <= core_z;
                    state <= M2;
                end
                M2: begin
                    z2    <= core_z;
                    state <= M1;
                end
                M1: begin
                    mid   <= mid_next;
                    state <= COMB;
                end
                COMB: begin
                    p         <= p_next;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_ctrl16.sv
// tb_karatsuba_ctrl16: table-driven directed vectors, a mid-operation reset
// sequence and a randomized run, all checked against plain a*b arithmetic.
// Inputs change 1ns after a falling edge; outputs are read at falling edges.
module tb_karatsuba_ctrl16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Expected products in acceptance order
    logic [31:0] expect_q[$];

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [31:0] vp;
        int          stall;
        bit          hold;
    } vec_t;

    vec_t vecs[9];

    karatsuba_ctrl16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    // Free-running 100MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard: products must leave in the same order operands were accepted
    initial begin
        logic [31:0] want;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (in_valid && in_ready)
                    expect_q.push_back(32'(a) * 32'(b));
                if (out_valid && out_ready) begin
                    if (expect_q.size() == 0) begin
                        check_output("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
                    end else begin
                        want = expect_q.pop_front();
                        check_output("scoreboard_p", p, want);
                    end
                end
            end
        end
    end

    // One full transaction; must be entered just after a falling edge
    task automatic apply_stimulus(input logic [15:0] op_a, input logic [15:0] op_b,
                                  input logic [31:0] exp_p, input int stall,
                                  input bit hold_valid, input string tag);
        int k;
        int lat;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_output($sformatf("%s_ready", tag), {31'b0, in_ready}, 32'd1);
        #1;
        a         = op_a;
        b         = op_b;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
            if (c == 1) begin
                check_output($sformatf("%s_busy", tag), {31'b0, busy}, 32'd1);
                check_output($sformatf("%s_not_ready", tag), {31'b0, in_ready}, 32'd0);
            end
            #1;
            if (!hold_valid)
                in_valid = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
        end
        check_output($sformatf("%s_latency", tag), 32'(lat), 32'd5);
        check_output($sformatf("%s_p", tag), p, exp_p);
        check_output($sformatf("%s_ready_in_done", tag), {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_output($sformatf("%s_stall_valid", tag), {31'b0, out_valid}, 32'd1);
            check_output($sformatf("%s_stall_p", tag), p, exp_p);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_output($sformatf("%s_release_valid", tag), {31'b0, out_valid}, 32'd0);
        check_output($sformatf("%s_release_ready", tag), {31'b0, in_ready}, 32'd1);
        check_output($sformatf("%s_release_busy", tag), {31'b0, busy}, 32'd0);
        check_output($sformatf("%s_p_kept", tag), p, exp_p);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          rstall;

        vecs[0] = '{16'h1111, 16'h1111, 32'h01234321, 0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b0};
        vecs[2] = '{16'h00FF, 16'hFF00, 32'h00FE0100, 0, 1'b0};
        vecs[3] = '{16'h0000, 16'hBEEF, 32'h00000000, 0, 1'b1};
        vecs[4] = '{16'hBEEF, 16'h0001, 32'h0000BEEF, 0, 1'b0};
        vecs[5] = '{16'h1234, 16'h5678, 32'h06260060, 10, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 32'h40000000, 2, 1'b0};
        vecs[7] = '{16'h00FF, 16'h00FF, 32'h0000FE01, 0, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 1, 1'b0};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'd0;
        b         = 16'd0;
        #1;
        rst_n = 1'b0;
        #2;
        check_output("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_p", p, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < 9; i++)
            apply_stimulus(vecs[i].va, vecs[i].vb, vecs[i].vp, vecs[i].stall,
                           vecs[i].hold, $sformatf("vec%0d", i));

        $display("[TB] reset during M1");
        while (!in_ready)
            @(negedge clk);
        #1;
        a         = 16'hFFFF;
        b         = 16'h0002;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            in_valid = 1'b0;
        end
        rst_n = 1'b0;
        expect_q.delete();
        #1;
        check_output("async_rst_p", p, 32'd0);
        check_output("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("async_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_output("no_stale_out_valid", {31'b0, out_valid}, 32'd0);
        end
        apply_stimulus(16'h0003, 16'h0005, 32'h0000000F, 0, 1'b0, "after_rst");

        $display("[TB] randomized run");
        for (int n = 0; n < 4000; n++) begin
            ra     = 16'($urandom);
            rb     = 16'($urandom);
            rstall = ($urandom_range(3) == 0) ? int'($urandom_range(4, 1)) : 0;
            apply_stimulus(ra, rb, 32'(ra) * 32'(rb), rstall, 1'b0, "rand");
        end

        @(negedge clk);
        @(negedge clk);
        check_output("queue_drained", 32'(expect_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
